// File: rtl/serial_wb_bridge.sv
// serial_wb_bridge: byte-stream command decoder driving a Wishbone master.
//
// Frame: CMD, CNT, AW/8 address bytes (MSB first), then for writes
// (CNT+1)*DW/8 data bytes (MSB first per word). CMD 0x01 = write burst,
// 0x02 = read burst, anything else returns status 0xEF.
// Read words are returned as DW/8 bytes MSB first. A status byte follows
// every command: 0x00 ok, 0xE1 err, 0xE2 timeout, 0xE3 retries exhausted,
// 0xEF bad command.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   rx_data_i/rx_valid_i    incoming byte strobe (no backpressure)
//   tx_data_o/tx_valid_o/tx_ready_i  outgoing byte handshake
//   wbm_*                   Wishbone master (classic, one word per cycle)
//   busy_o                  high whenever the FSM is not idle
//
// Optional feature macro: SERIAL_WB_RETRY_EN. When defined, rty re-issues
// the same word up to RETRIES times before aborting with 0xE3; otherwise
// rty is handled exactly like err.
module serial_wb_bridge #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAXBURST = 256,
  parameter int TIMEOUT  = 255,
  parameter int RETRIES  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_lock_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic            busy_o
);

  localparam int NAB = AW / 8;
  localparam int NDB = DW / 8;
  localparam logic [3:0]    ALAST = 4'(NAB - 1);
  localparam logic [3:0]    DLAST = 4'(NDB - 1);
  localparam logic [7:0]    CMASK = 8'(MAXBURST - 1);
  localparam logic [15:0]   TLAST = 16'(TIMEOUT - 1);
  localparam logic [AW-1:0] AINC  = AW'(NDB);

`ifdef SERIAL_WB_RETRY_EN
  localparam int         RLIM   = RETRIES;
  localparam logic [7:0] RTY_ST = 8'hE3;
`else
  // No retry budget: the first rty is final and reports like err.
  localparam int         RLIM   = 0 * RETRIES;
  localparam logic [7:0] RTY_ST = 8'hE1;
`endif
  localparam logic [15:0] RLIM16 = 16'(RLIM);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT, S_ADDR, S_WDATA, S_WB, S_RDATA_TX, S_DRAIN, S_STATUS_TX
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [7:0]    left_q, left_d;     // words remaining after the current one
  logic [3:0]    bidx_q, bidx_d;     // byte index within address/word
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat_q, rdat_d;     // shifts left as bytes are sent
  logic [7:0]    status_q, status_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [15:0]   rtry_q, rtry_d;
  logic          gap_q, gap_d;       // one idle cycle between retry attempts
  logic          lock_q, lock_d;
  logic          abort;
  logic [7:0]    abort_st;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      left_q   <= '0;
      bidx_q   <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      tmo_q    <= '0;
      rtry_q   <= '0;
      gap_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      left_q   <= left_d;
      bidx_q   <= bidx_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      rtry_q   <= rtry_d;
      gap_q    <= gap_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    left_d   = left_q;
    bidx_d   = bidx_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    rtry_d   = rtry_q;
    gap_d    = gap_q;
    lock_d   = lock_q;
    abort    = 1'b0;
    abort_st = 8'h00;

    case (state_q)
      S_IDLE: if (rx_valid_i) begin
        if (rx_data_i == 8'h01 || rx_data_i == 8'h02) begin
          we_d    = (rx_data_i == 8'h01);
          state_d = S_CNT;
        end else begin
          status_d = 8'hEF;
          state_d  = S_STATUS_TX;
        end
      end
      S_CNT: if (rx_valid_i) begin
        left_d  = rx_data_i & CMASK;
        bidx_d  = '0;
        state_d = S_ADDR;
      end
      S_ADDR: if (rx_valid_i) begin
        adr_d  = (adr_q << 8) | AW'(rx_data_i);
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == ALAST) begin
          bidx_d = '0;
          if (we_q) state_d = S_WDATA;
          else begin
            state_d = S_WB;
            tmo_d   = '0;
            rtry_d  = '0;
            lock_d  = 1'b1;
          end
        end
      end
      S_WDATA: if (rx_valid_i) begin
        wdat_d = (wdat_q << 8) | DW'(rx_data_i);
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == DLAST) begin
          bidx_d  = '0;
          state_d = S_WB;
          tmo_d   = '0;
          rtry_d  = '0;
          lock_d  = 1'b1;
        end
      end
      S_WB: begin
        if (gap_q) gap_d = 1'b0;
        else if (wbm_err_i) begin
          abort    = 1'b1;
          abort_st = 8'hE1;
        end else if (wbm_rty_i) begin
          if (rtry_q < RLIM16) begin
            rtry_d = rtry_q + 16'd1;
            gap_d  = 1'b1;
            tmo_d  = '0;
          end else begin
            abort    = 1'b1;
            abort_st = RTY_ST;
          end
        end else if (wbm_ack_i) begin
          adr_d  = adr_q + AINC;
          bidx_d = '0;
          if (!we_q) begin
            rdat_d  = wbm_dat_i;
            state_d = S_RDATA_TX;
          end else if (left_q == 8'd0) begin
            status_d = 8'h00;
            state_d  = S_STATUS_TX;
          end else begin
            left_d  = left_q - 8'd1;
            state_d = S_WDATA;
          end
        end else if (tmo_q == TLAST) begin
          abort    = 1'b1;
          abort_st = 8'hE2;
        end else tmo_d = tmo_q + 16'd1;
      end
      S_RDATA_TX: if (tx_ready_i) begin
        rdat_d = rdat_q << 8;
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == DLAST) begin
          bidx_d = '0;
          if (left_q == 8'd0) begin
            status_d = 8'h00;
            state_d  = S_STATUS_TX;
          end else begin
            left_d  = left_q - 8'd1;
            state_d = S_WB;
            tmo_d   = '0;
            rtry_d  = '0;
          end
        end
      end
      S_DRAIN: if (rx_valid_i) begin
        bidx_d = bidx_q + 4'd1;
        if (bidx_q == DLAST) begin
          bidx_d = '0;
          if (left_q == 8'd0) state_d = S_STATUS_TX;
          else left_d = left_q - 8'd1;
        end
      end
      S_STATUS_TX: if (tx_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A write that aborts with words still outstanding must swallow their
    // data bytes so the next frame is parsed from its CMD byte.
    if (abort) begin
      status_d = abort_st;
      bidx_d   = '0;
      if (we_q && left_q != 8'd0) begin
        left_d  = left_q - 8'd1;
        state_d = S_DRAIN;
      end else state_d = S_STATUS_TX;
    end

    if (state_d == S_STATUS_TX) lock_d = 1'b0;
  end

  // Bus strobes decode straight from state so reset clears them at once.
  assign wbm_stb_o  = (state_q == S_WB) && !gap_q;
  assign wbm_cyc_o  = wbm_stb_o;
  assign wbm_we_o   = wbm_stb_o && we_q;
  assign wbm_sel_o  = {NDB{wbm_stb_o}};
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = wdat_q;
  assign wbm_lock_o = lock_q;
  assign tx_valid_o = (state_q == S_RDATA_TX) || (state_q == S_STATUS_TX);
  assign tx_data_o  = (state_q == S_STATUS_TX) ? status_q : rdat_q[DW-1 -: 8];
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_wb_bridge.sv
// Directed bench for serial_wb_bridge (AW=DW=32, TIMEOUT=16, RETRIES=3).
module tb_serial_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_lock;
  logic        wbm_ack = 1'b0, wbm_err = 1'b0, wbm_rty = 1'b0;
  logic        busy;

  serial_wb_bridge #(.AW(32), .DW(32), .MAXBURST(256), .TIMEOUT(16), .RETRIES(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc),
    .wbm_stb_o(wbm_stb), .wbm_lock_o(wbm_lock),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: modes 0 ack, 1 err, 2 silent, 3 rty rty_n times then ack.
  int slv_mode = 0, slv_delay = 0, rty_n = 0;
  int wcnt = 0, stb_cycles = 0, stb_rises = 0;
  bit stb_prev = 1'b0;
  logic [31:0] rd_q[$];
  logic [31:0] adr_log[$], dat_log[$];
  logic        we_log[$];
  logic [3:0]  sel_log[$];
  logic [7:0]  tx_log[$];
  logic        lock_log[$];

  always begin
    @(posedge clk);
    #1;
    wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
    if (wbm_stb && !rst) begin
      stb_cycles++;
      if (!stb_prev) stb_rises++;
      if (slv_mode != 2 && wcnt >= slv_delay) begin
        wcnt = 0;
        adr_log.push_back(wbm_adr); dat_log.push_back(wbm_dat_o);
        we_log.push_back(wbm_we);   sel_log.push_back(wbm_sel);
        if (slv_mode == 1) wbm_err = 1'b1;
        else if (slv_mode == 3 && rty_n > 0) begin wbm_rty = 1'b1; rty_n--; end
        else begin
          wbm_ack = 1'b1;
          if (!wbm_we) wbm_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end
      end else wcnt++;
    end else wcnt = 0;
    stb_prev = wbm_stb;
  end

  always @(negedge clk)
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      lock_log.push_back(wbm_lock);
    end

  task automatic clear_logs();
    adr_log.delete(); dat_log.delete(); we_log.delete(); sel_log.delete();
    tx_log.delete(); lock_log.delete(); rd_q.delete();
    stb_cycles = 0; stb_rises = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] cnt, input logic [31:0] adr);
    send_byte(cmd); send_byte(cnt); send_word(adr);
  endtask

  task automatic wait_tx(input int n, input string name);
    for (int i = 0; i < 400 && tx_log.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_log.size() != n) begin
      n_bad++; $display("FAIL %s_txcount: got %0d want %0d", name, tx_log.size(), n);
    end
  endtask

  task automatic wait_bus_done(input string name);
    int i;
    for (i = 0; i < 200 && !wbm_cyc; i++) @(negedge clk);
    for (i = 0; i < 200 && wbm_cyc; i++) @(negedge clk);
    n_cmp++;
    if (wbm_cyc) begin n_bad++; $display("FAIL %s_busdone: cyc stuck got 1 want 0", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_valid, wbm_cyc, wbm_stb, wbm_lock, wbm_we, busy} !== 6'b0 ||
        wbm_sel !== 4'h0 || wbm_adr !== 32'h0 || tx_data !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v%b c%b s%b l%b w%b b%b sel%h adr%h tx%h want all zero",
               tx_valid, wbm_cyc, wbm_stb, wbm_lock, wbm_we, busy, wbm_sel, wbm_adr, tx_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    clear_logs(); slv_mode = 0; slv_delay = 2;
    send_hdr(8'h01, 8'h00, 32'h0000_1000);
    send_word(32'hDEAD_BEEF);
    wait_tx(1, "write");
    n_cmp++;
    if (adr_log.size() != 1 || adr_log[0] !== 32'h1000 || dat_log[0] !== 32'hDEADBEEF ||
        we_log[0] !== 1'b1 || sel_log[0] !== 4'hF) begin
      n_bad++; $display("FAIL write_bus: got n%0d adr %h dat %h we %b sel %h want 1 1000 deadbeef 1 f",
                        adr_log.size(), adr_log[0], dat_log[0], we_log[0], sel_log[0]);
    end
    n_cmp++;
    if (stb_cycles != 3) begin n_bad++; $display("FAIL write_stbcycles: got %0d want 3", stb_cycles); end
    n_cmp++;
    if (tx_log[0] !== 8'h00) begin n_bad++; $display("FAIL write_status: got %h want 00", tx_log[0]); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy: got %b want 0", busy); end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_b[13];
    clear_logs(); slv_mode = 0; slv_delay = 0;
    rd_q.push_back(32'h11111111); rd_q.push_back(32'h22222222); rd_q.push_back(32'h33333333);
    exp_b = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
              8'h33, 8'h33, 8'h33, 8'h33, 8'h00};
    tx_ready = 1'b0;
    send_hdr(8'h02, 8'h02, 32'h0000_2000);
    for (int i = 0; i < 100 && adr_log.size() < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    // Transmitter stalled: first byte held, no further bus traffic.
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11 || wbm_stb !== 1'b0) begin
      n_bad++; $display("FAIL read_stall: got v%b d%h stb%b want v1 d11 stb0", tx_valid, tx_data, wbm_stb);
    end
    tx_ready = 1'b1;
    wait_tx(13, "read");
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (tx_log[i] !== exp_b[i]) begin
        n_bad++; $display("FAIL read_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (adr_log.size() != 3 || adr_log[0] !== 32'h2000 || adr_log[1] !== 32'h2004 ||
        adr_log[2] !== 32'h2008) begin
      n_bad++; $display("FAIL read_adr: got n%0d %h %h %h want 3 2000 2004 2008",
                        adr_log.size(), adr_log[0], adr_log[1], adr_log[2]);
    end
    n_cmp++;
    if (lock_log.size() != 13 || lock_log[0] !== 1'b1 || lock_log[11] !== 1'b1 || lock_log[12] !== 1'b0) begin
      n_bad++; $display("FAIL read_lock: got first %b last_data %b status %b want 1 1 0",
                        lock_log[0], lock_log[11], lock_log[12]);
    end
    n_cmp++;
    if (stb_rises != 3) begin n_bad++; $display("FAIL read_stbrises: got %0d want 3", stb_rises); end
  endtask

  task automatic test_timeout();
    clear_logs(); slv_mode = 2;
    send_hdr(8'h02, 8'h00, 32'h0000_3000);
    wait_tx(1, "timeout");
    n_cmp++;
    if (stb_cycles != 16) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 16", stb_cycles); end
    n_cmp++;
    if (tx_log[0] !== 8'hE2) begin n_bad++; $display("FAIL timeout_status: got %h want e2", tx_log[0]); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_err();
    clear_logs(); slv_mode = 1; slv_delay = 0;
    send_hdr(8'h01, 8'h01, 32'h0000_4000);
    send_word(32'h1122_3344);
    wait_bus_done("werr");
    send_word(32'h5566_7788);
    wait_tx(1, "werr");
    n_cmp++;
    if (stb_rises != 1) begin n_bad++; $display("FAIL werr_stbrises: got %0d want 1", stb_rises); end
    n_cmp++;
    if (tx_log[0] !== 8'hE1) begin n_bad++; $display("FAIL werr_status: got %h want e1", tx_log[0]); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL werr_busy: got %b want 0", busy); end
  endtask

  task automatic test_bad_cmd();
    clear_logs(); slv_mode = 0;
    send_byte(8'h55);
    wait_tx(1, "badcmd");
    n_cmp++;
    if (tx_log[0] !== 8'hEF) begin n_bad++; $display("FAIL badcmd_status: got %h want ef", tx_log[0]); end
    n_cmp++;
    if (stb_rises != 0) begin n_bad++; $display("FAIL badcmd_bus: got %0d cycles want 0", stb_rises); end
  endtask

  task automatic test_wrap();
    clear_logs(); slv_mode = 0; slv_delay = 0;
    rd_q.push_back(32'hAAAAAAAA); rd_q.push_back(32'h55555555);
    send_hdr(8'h02, 8'h01, 32'hFFFF_FFFC);
    wait_tx(9, "wrap");
    n_cmp++;
    if (adr_log.size() != 2 || adr_log[0] !== 32'hFFFFFFFC || adr_log[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_adr: got %h %h want fffffffc 00000000", adr_log[0], adr_log[1]);
    end
    n_cmp++;
    if (tx_log[4] !== 8'h55 || tx_log[8] !== 8'h00) begin
      n_bad++; $display("FAIL wrap_data: got %h %h want 55 00", tx_log[4], tx_log[8]);
    end
  endtask

  task automatic test_retry();
`ifdef SERIAL_WB_RETRY_EN
    clear_logs(); slv_mode = 3; slv_delay = 0; rty_n = 2;
    rd_q.push_back(32'hCAFEF00D);
    send_hdr(8'h02, 8'h00, 32'h0000_5000);
    wait_tx(5, "rty_ok");
    n_cmp++;
    if (stb_rises != 3) begin n_bad++; $display("FAIL rty_ok_stbrises: got %0d want 3", stb_rises); end
    n_cmp++;
    if (tx_log[0] !== 8'hCA || tx_log[3] !== 8'h0D || tx_log[4] !== 8'h00) begin
      n_bad++; $display("FAIL rty_ok_tx: got %h %h %h want ca 0d 00", tx_log[0], tx_log[3], tx_log[4]);
    end
    clear_logs(); slv_mode = 3; rty_n = 10;
    send_hdr(8'h02, 8'h00, 32'h0000_5000);
    wait_tx(1, "rty_fail");
    n_cmp++;
    if (stb_rises != 4) begin n_bad++; $display("FAIL rty_fail_stbrises: got %0d want 4", stb_rises); end
    n_cmp++;
    if (tx_log[0] !== 8'hE3) begin n_bad++; $display("FAIL rty_fail_status: got %h want e3", tx_log[0]); end
`else
    clear_logs(); slv_mode = 3; slv_delay = 0; rty_n = 10;
    send_hdr(8'h02, 8'h00, 32'h0000_5000);
    wait_tx(1, "rty");
    n_cmp++;
    if (stb_rises != 1) begin n_bad++; $display("FAIL rty_stbrises: got %0d want 1", stb_rises); end
    n_cmp++;
    if (tx_log[0] !== 8'hE1) begin n_bad++; $display("FAIL rty_status: got %h want e1", tx_log[0]); end
`endif
    rty_n = 0;
  endtask

  task automatic test_reset_mid();
    clear_logs(); slv_mode = 2;
    send_hdr(8'h02, 8'h00, 32'h0000_6000);
    for (int i = 0; i < 50 && !wbm_stb; i++) @(negedge clk);
    n_cmp++;
    if (wbm_stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_start: stb got %b want 1", wbm_stb); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wbm_cyc, wbm_stb, wbm_lock, busy} !== 4'b0) begin
      n_bad++; $display("FAIL rstmid_abort: got cyc%b stb%b lock%b busy%b want 0000",
                        wbm_cyc, wbm_stb, wbm_lock, busy);
    end
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (tx_log.size() != 0) begin n_bad++; $display("FAIL rstmid_tx: got %0d bytes want 0", tx_log.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_burst();
    test_timeout();
    test_write_err();
    test_bad_cmd();
    test_wrap();
    test_retry();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
